pipeline_hazard_ctrl: RTL and testbench

//  Sequences the ID/EX pipeline register and its neighbours (PC, IF/ID, EX/MEM).

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the ID/EX hazard controller: FSM states, the bundle of
// pipeline control strobes and the canned strobe patterns the FSM selects from.
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        MC_DONE = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic mc_start;
        logic mc_abort;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE    = '0;
    // Freeze everything up to ID/EX and feed bubbles into EX/MEM while the unit works.
    localparam hz_ctrl_t CTRL_MC_HOLD = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                          id_ex_stall: 1'b1, id_ex_flush: 1'b0,
                                          ex_mem_bubble: 1'b1, mc_start: 1'b0,
                                          mc_abort: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing around the ID/EX register: load-use interlock, EX
// redirects and a watchdog-guarded handshake with a multi-cycle EX unit.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_idx,
    input  logic [4:0]       id_rs2_idx,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_idx,
    input  logic             ex_mem_read,
    input  logic             ex_mc_op,
    input  logic             ex_redirect,
    input  logic             mc_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mc_start,
    output logic             mc_abort,
    output logic             mc_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       dbg_state
);

    localparam int WC_W = $clog2(MC_TIMEOUT + 1);

    hz_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            mc_error_q, mc_error_nxt;
    hz_ctrl_t        ctrl;
    logic            load_use;
    logic            redirect_acc;

    assign load_use = ex_mem_read && (ex_rd_idx != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_idx == ex_rd_idx)) ||
                       (id_uses_rs2 && (id_rs2_idx == ex_rd_idx)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            mc_error_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            mc_error_q <= mc_error_nxt;
        end
    end

    // Handshake: mc_start is a one-cycle request while the op sits in ID/EX;
    // the unit answers with a one-cycle mc_done, only honoured in MC_WAIT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mc_error_nxt = mc_error_q;
        ctrl         = CTRL_NONE;
        redirect_acc = 1'b0;
        case (state)
            RUN, MC_DONE: begin
                state_nxt = RUN;
                if (ex_redirect) begin
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    redirect_acc     = 1'b1;
                end else if (ex_mc_op && (state == RUN)) begin
                    ctrl          = CTRL_MC_HOLD;
                    ctrl.mc_start = 1'b1;
                    wait_cnt_nxt  = WC_W'(1);
                    state_nxt     = MC_WAIT;
                end else if (load_use) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_stall = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end
            end
            MC_WAIT: begin
                ctrl = CTRL_MC_HOLD;
                if (mc_done) begin
                    state_nxt = MC_DONE;
                end else if (wait_cnt == WC_W'(MC_TIMEOUT)) begin
                    ctrl.mc_abort    = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    mc_error_nxt     = 1'b1;
                    state_nxt        = RUN;
                end else begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
        // Nothing may disturb the pipeline while reset is held.
        if (!reset) begin
            ctrl         = CTRL_NONE;
            redirect_acc = 1'b0;
        end
    end

    assign pc_stall      = ctrl.pc_stall;
    assign if_id_stall   = ctrl.if_id_stall;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_stall   = ctrl.id_ex_stall;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mc_start      = ctrl.mc_start;
    assign mc_abort      = ctrl.mc_abort;
    assign mc_error      = mc_error_q;
    assign dbg_state     = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl.pc_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_acc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: instance A uses default parameters,
// instance B a short watchdog and 3-bit counters for timeout and saturation.
module tb_pipeline_hazard_ctrl;

    localparam int W = 27;

    // ctrl order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //             ex_mem_bubble, mc_start, mc_abort
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_RD   = 8'b0010_1000;
    localparam logic [7:0] C_MCS  = 8'b1101_0110;
    localparam logic [7:0] C_MCW  = 8'b1101_0100;
    localparam logic [7:0] C_ABT  = 8'b1101_1101;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;
    logic ra, rb, sel, sel_n;

    logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_mc_op, ex_redirect, mc_done;

    logic       pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_stall_a, id_ex_flush_a;
    logic       ex_mem_bubble_a, mc_start_a, mc_abort_a, mc_error_a;
    logic [31:0] stall_a, flush_a;
    logic [1:0] st_a;

    logic       pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_stall_b, id_ex_flush_b;
    logic       ex_mem_bubble_b, mc_start_b, mc_abort_b, mc_error_b;
    logic [2:0] stall_b, flush_b;
    logic [1:0] st_b;

    pipeline_hazard_ctrl dut_a (
        .clk(clk), .reset(reset_a),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_idx(ex_rd_idx), .ex_mem_read(ex_mem_read), .ex_mc_op(ex_mc_op),
        .ex_redirect(ex_redirect), .mc_done(mc_done),
        .pc_stall(pc_stall_a), .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
        .id_ex_stall(id_ex_stall_a), .id_ex_flush(id_ex_flush_a),
        .ex_mem_bubble(ex_mem_bubble_a), .mc_start(mc_start_a), .mc_abort(mc_abort_a),
        .mc_error(mc_error_a), .stall_cycles(stall_a), .flush_events(flush_a),
        .dbg_state(st_a)
    );

    pipeline_hazard_ctrl #(.CNT_W(3), .MC_TIMEOUT(4)) dut_b (
        .clk(clk), .reset(reset_b),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_idx(ex_rd_idx), .ex_mem_read(ex_mem_read), .ex_mc_op(ex_mc_op),
        .ex_redirect(ex_redirect), .mc_done(mc_done),
        .pc_stall(pc_stall_b), .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
        .id_ex_stall(id_ex_stall_b), .id_ex_flush(id_ex_flush_b),
        .ex_mem_bubble(ex_mem_bubble_b), .mc_start(mc_start_b), .mc_abort(mc_abort_b),
        .mc_error(mc_error_b), .stall_cycles(stall_b), .flush_events(flush_b),
        .dbg_state(st_b)
    );

    logic [W-1:0] act_a, act_b;
    assign act_a = {pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_stall_a, id_ex_flush_a,
                    ex_mem_bubble_a, mc_start_a, mc_abort_a, st_a, mc_error_a,
                    stall_a[7:0], flush_a[7:0]};
    assign act_b = {pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_stall_b, id_ex_flush_b,
                    ex_mem_bubble_b, mc_start_b, mc_abort_b, st_b, mc_error_b,
                    5'b0, stall_b, 5'b0, flush_b};

    // scoreboard
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    function automatic logic [W-1:0] e(input logic [7:0] c, input logic [1:0] st,
                                       input logic er, input logic [7:0] sc,
                                       input logic [7:0] fe);
        return {c, st, er, sc, fe};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, act_v;
            string        tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act_v = sel ? act_b : act_a;
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got ctrl=%b st=%0d err=%b sc=%0d fe=%0d, want ctrl=%b st=%0d err=%b sc=%0d fe=%0d",
                         tag, act_v[26:19], act_v[18:17], act_v[16], act_v[15:8], act_v[7:0],
                         exp_v[26:19], exp_v[18:17], exp_v[16], exp_v[15:8], exp_v[7:0]);
            end
        end
    end

    // driver: one call = one clock cycle of inputs plus its expected response
    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic mc,
                        input logic rdr, input logic dn, input logic [W-1:0] exp_v);
        @(posedge clk);
        #1;
        reset_a     = ra;
        reset_b     = rb;
        sel         = sel_n;
        id_rs1_idx  = rs1;
        id_uses_rs1 = u1;
        id_rs2_idx  = rs2;
        id_uses_rs2 = u2;
        ex_rd_idx   = rd;
        ex_mem_read = mr;
        ex_mc_op    = mc;
        ex_redirect = rdr;
        mc_done     = dn;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input logic [W-1:0] exp_v);
        step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_v);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_a = 1'b0; reset_b = 1'b0; ra = 1'b0; rb = 1'b0; sel = 1'b0; sel_n = 1'b0;
        id_rs1_idx = '0; id_rs2_idx = '0; ex_rd_idx = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_mc_op = 1'b0; ex_redirect = 1'b0; mc_done = 1'b0;

        // ---- instance A, default parameters; B held in reset ----
        idle("a_in_reset", e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        ra = 1'b1;
        idle("a_reset_release", e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        step("lu_rs1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, e(C_LU, 2'd0, 1'b0, 8'd0, 8'd0));
        step("lu_cleared", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e(C_NONE, 2'd0, 1'b0, 8'd1, 8'd0));
        step("lu_x0", 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, e(C_NONE, 2'd0, 1'b0, 8'd1, 8'd0));
        step("lu_rs2_unused", 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, e(C_NONE, 2'd0, 1'b0, 8'd1, 8'd0));
        step("lu_rs2", 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, e(C_LU, 2'd0, 1'b0, 8'd1, 8'd0));
        idle("after_lu_rs2", e(C_NONE, 2'd0, 1'b0, 8'd2, 8'd0));
        step("redirect_over_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, e(C_RD, 2'd0, 1'b0, 8'd2, 8'd0));
        idle("after_redirect", e(C_NONE, 2'd0, 1'b0, 8'd2, 8'd1));
        step("mc_start", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCS, 2'd0, 1'b0, 8'd2, 8'd1));
        step("mc_wait1", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b0, 8'd3, 8'd1));
        step("mc_wait_redirect", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, e(C_MCW, 2'd1, 1'b0, 8'd4, 8'd1));
        step("mc_wait_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b0, 8'd5, 8'd1));
        step("mc_wait4", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b0, 8'd6, 8'd1));
        step("mc_wait_done", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, e(C_MCW, 2'd1, 1'b0, 8'd7, 8'd1));
        step("mc_done_state", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_NONE, 2'd2, 1'b0, 8'd8, 8'd1));
        step("stray_mc_done", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(C_NONE, 2'd0, 1'b0, 8'd8, 8'd1));
        step("redirect_over_mc", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, e(C_RD, 2'd0, 1'b0, 8'd8, 8'd1));
        idle("a_end", e(C_NONE, 2'd0, 1'b0, 8'd8, 8'd2));

        // ---- instance B: MC_TIMEOUT=4, CNT_W=3; A held in reset ----
        ra = 1'b0; rb = 1'b1; sel_n = 1'b1;
        idle("b_reset_release", e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        step("b_mc_start", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCS, 2'd0, 1'b0, 8'd0, 8'd0));
        for (int i = 1; i <= 3; i++) begin
            step("b_wait", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                 e(C_MCW, 2'd1, 1'b0, 8'(i), 8'd0));
        end
        step("b_abort", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_ABT, 2'd1, 1'b0, 8'd4, 8'd0));
        idle("b_error_sticky", e(C_NONE, 2'd0, 1'b1, 8'd5, 8'd0));
        step("b_stray_done", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(C_NONE, 2'd0, 1'b1, 8'd5, 8'd0));
        step("b_mc_start2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCS, 2'd0, 1'b1, 8'd5, 8'd0));
        step("b_wait_sc6", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b1, 8'd6, 8'd0));
        step("b_wait_sc7", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b1, 8'd7, 8'd0));
        step("b_wait_sat", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b1, 8'd7, 8'd0));
        step("b_abort2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_ABT, 2'd1, 1'b1, 8'd7, 8'd0));
        idle("b_sat_hold", e(C_NONE, 2'd0, 1'b1, 8'd7, 8'd0));
        step("b_mc_start3", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCS, 2'd0, 1'b1, 8'd7, 8'd0));
        step("b_wait3", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, e(C_MCW, 2'd1, 1'b1, 8'd7, 8'd0));
        rb = 1'b0;
        step("b_reset_mid_wait", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        idle("b_reset_held", e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        rb = 1'b1;
        idle("b_after_reset", e(C_NONE, 2'd0, 1'b0, 8'd0, 8'd0));
        step("b_mc_fresh", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, e(C_MCS, 2'd0, 1'b0, 8'd0, 8'd0));

        // final report
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
